// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, helpers and parameter legality checks for fifo_sync_asym_packer.
package fifo_pkg;
   localparam string PK_MSB_FIRST = "MSB_FIRST";
   localparam string PK_LSB_FIRST = "LSB_FIRST";
   function automatic int f_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic bit f_pow2(input int v);
      return v > 0 && (v & (v - 1)) == 0;
   endfunction
   function automatic bit f_params_ok(input int ratio, depth, pfa, pfn, pea, pen, busy);
      return f_pow2(ratio) && ratio <= 8 && f_pow2(depth) && depth >= 4 &&
             pfn <= pfa && pen >= pea && busy >= 1;
   endfunction
endpackage

// File: rtl/fifo_sync_asym_packer_if.sv
// fifo_sync_asym_packer_if: write/read/status bundle between a packer FIFO and its neighbours.
interface fifo_sync_asym_packer_if #(
   parameter int WR_WIDTH = 16,
   parameter int RATIO    = 2,
   parameter int DEPTH    = 512
);
   import fifo_pkg::*;
   localparam int CW = f_clog2(DEPTH) + 1;
   logic                      flush_i;
   logic                      wr_en_i;
   logic [WR_WIDTH-1:0]       wdata;
   logic                      rd_en_i;
   logic [WR_WIDTH*RATIO-1:0] rdata;
   logic                      rd_valid_o;
   logic                      full_o;
   logic                      empty_o;
   logic                      prog_full_o;
   logic                      prog_empty_o;
   logic [CW-1:0]             count_o;
   logic                      overflow_o;
   logic                      underflow_o;
   logic                      rst_busy_o;
   modport master (
      output flush_i, wr_en_i, wdata, rd_en_i,
      input  rdata, rd_valid_o, full_o, empty_o, prog_full_o, prog_empty_o,
             count_o, overflow_o, underflow_o, rst_busy_o
   );
   modport slave (
      input  flush_i, wr_en_i, wdata, rd_en_i,
      output rdata, rd_valid_o, full_o, empty_o, prog_full_o, prog_empty_o,
             count_o, overflow_o, underflow_o, rst_busy_o
   );
endinterface

// File: rtl/fifo_width_packer.sv
// fifo_width_packer: gathers RATIO narrow words into one wide word and strobes on completion.
module fifo_width_packer
   import fifo_pkg::*;
#(
   parameter int    WR_WIDTH   = 16,
   parameter int    RATIO      = 2,
   parameter string PACK_ORDER = "MSB_FIRST"
) (
   input  logic                      clk_i,
   input  logic                      a_rst_n_i,
   input  logic                      flush_i,
   input  logic                      accept_i,
   input  logic [WR_WIDTH-1:0]       wdata_i,
   output logic                      last_o,
   output logic                      done_o,
   output logic [WR_WIDTH*RATIO-1:0] word_o
);
   localparam int PCW = RATIO > 1 ? f_clog2(RATIO) : 1;
   localparam bit MSB = PACK_ORDER == PK_MSB_FIRST;
   logic [PCW-1:0]            r_cnt;
   logic [PCW-1:0]            w_slice;
   logic [WR_WIDTH*RATIO-1:0] r_buf;
   assign last_o  = r_cnt == PCW'(RATIO - 1);
   assign done_o  = accept_i && last_o;
   assign w_slice = MSB ? PCW'(RATIO - 1) - r_cnt : r_cnt;
   // The completed word includes the word being written this cycle.
   always_comb begin
      word_o = r_buf;
      word_o[int'(w_slice)*WR_WIDTH +: WR_WIDTH] = wdata_i;
   end
   always_ff @(posedge clk_i or negedge a_rst_n_i)
      if (!a_rst_n_i) begin
         r_cnt <= '0;
         r_buf <= '0;
      end else if (flush_i) begin
         r_cnt <= '0;
      end else if (accept_i) begin
         r_cnt <= last_o ? '0 : r_cnt + 1'b1;
         r_buf <= word_o;
      end
endmodule

// File: rtl/fifo_sync_asym_packer.sv
// fifo_sync_asym_packer: single-clock FIFO packing RATIO narrow writes into one wide read word,
// with hysteretic level flags, sticky-free error pulses, flush and post-reset busy window.
module fifo_sync_asym_packer
   import fifo_pkg::*;
#(
   parameter int    WR_WIDTH        = 16,
   parameter int    RATIO           = 2,
   parameter string PACK_ORDER      = "MSB_FIRST",
   parameter int    DEPTH           = 512,
   parameter bit    OUTPUT_REG      = 0,
   parameter int    PF_ASSERT       = 128,
   parameter int    PF_NEGATE       = 96,
   parameter int    PE_ASSERT       = 8,
   parameter int    PE_NEGATE       = 16,
   parameter int    RST_BUSY_CYCLES = 2
) (
   input  logic                     clk_i,
   input  logic                     a_rst_n_i,
   fifo_sync_asym_packer_if.slave   bus
);
   localparam int AW = f_clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = WR_WIDTH * RATIO;
   localparam int BW = f_clog2(RST_BUSY_CYCLES + 1);
   localparam bit ORDER_OK = PACK_ORDER == PK_MSB_FIRST || PACK_ORDER == PK_LSB_FIRST;
   if (!ORDER_OK || !f_params_ok(RATIO, DEPTH, PF_ASSERT, PF_NEGATE, PE_ASSERT, PE_NEGATE,
                                 RST_BUSY_CYCLES)) begin : g_bad_params
      $error("fifo_sync_asym_packer: illegal parameter combination");
   end
   logic [RW-1:0] r_mem [DEPTH];
   logic [RW-1:0] r_q, r_rdata, w_word;
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_cnt;
   logic [BW-1:0] r_bcnt;
   logic          r_v1, r_valid, r_pf, r_pe, r_of, r_uf;
   logic          w_busy, w_fl, w_wr, w_rd, w_full, w_empty, w_last, w_done, w_pop, w_adv;
   assign w_busy  = r_bcnt != '0;
   assign w_fl    = bus.flush_i && !w_busy;
   assign w_wr    = bus.wr_en_i && !w_busy && !bus.flush_i;
   assign w_rd    = bus.rd_en_i && !w_busy && !bus.flush_i;
   assign w_full  = (r_cnt == CW'(DEPTH)) && w_last;
   assign w_empty = r_cnt == '0;
   assign w_pop   = w_rd && !w_empty;
   // A flush kills a read already in the output pipe.
   assign w_adv   = OUTPUT_REG ? r_v1 && !w_fl : w_pop;
   fifo_width_packer #(
      .WR_WIDTH  (WR_WIDTH),
      .RATIO     (RATIO),
      .PACK_ORDER(PACK_ORDER)
   ) u_packer (
      .clk_i    (clk_i),
      .a_rst_n_i(a_rst_n_i),
      .flush_i  (w_fl),
      .accept_i (w_wr && !w_full),
      .wdata_i  (bus.wdata),
      .last_o   (w_last),
      .done_o   (w_done),
      .word_o   (w_word)
   );
   always_ff @(posedge clk_i) begin
      if (w_done) r_mem[r_wptr] <= w_word;
      if (w_pop) r_q <= r_mem[r_rptr];
   end
   always_ff @(posedge clk_i or negedge a_rst_n_i)
      if (!a_rst_n_i) begin
         r_bcnt  <= BW'(RST_BUSY_CYCLES);
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
         r_v1    <= 1'b0;
         r_valid <= 1'b0;
         r_rdata <= '0;
         r_pf    <= 1'b0;
         r_pe    <= 1'b1;
         r_of    <= 1'b0;
         r_uf    <= 1'b0;
      end else begin
         if (w_busy) r_bcnt <= r_bcnt - 1'b1;
         r_of    <= w_wr && w_full;
         r_uf    <= w_rd && w_empty;
         r_v1    <= w_pop;
         r_valid <= w_adv;
         if (w_adv) r_rdata <= OUTPUT_REG ? r_q : r_mem[r_rptr];
         if (w_fl) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_pf   <= 1'b0;
            r_pe   <= 1'b1;
         end else begin
            if (w_done) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_done) - CW'(w_pop);
            r_pf  <= int'(r_cnt) >= PF_ASSERT ? 1'b1 : int'(r_cnt) < PF_NEGATE ? 1'b0 : r_pf;
            r_pe  <= int'(r_cnt) <= PE_ASSERT ? 1'b1 : int'(r_cnt) > PE_NEGATE ? 1'b0 : r_pe;
         end
      end
   assign bus.rdata        = r_rdata;
   assign bus.rd_valid_o   = r_valid;
   assign bus.full_o       = w_full;
   assign bus.empty_o      = w_empty;
   assign bus.prog_full_o  = r_pf;
   assign bus.prog_empty_o = r_pe;
   assign bus.count_o      = r_cnt;
   assign bus.overflow_o   = r_of;
   assign bus.underflow_o  = r_uf;
   assign bus.rst_busy_o   = w_busy;
endmodule

// File: tb/tb_fifo_sync_asym_packer.sv
// tb_fifo_sync_asym_packer: directed and randomized checks of the packer FIFO against a queue model.
module tb_fifo_sync_asym_packer;
   localparam int W = 16, R = 2, D = 8;
   logic clk = 1'b0;
   logic a_rst_n = 1'b0;
   int n_chk = 0, n_pass = 0;
   logic [31:0] m_q[$];
   logic [15:0] m_part[$];
   logic [31:0] m_rdata;
   bit m_valid, m_of, m_uf, m_pf, m_pe;
   int m_bl;
   always #5 clk = ~clk;
   fifo_sync_asym_packer_if #(.WR_WIDTH(W), .RATIO(R), .DEPTH(D)) b1 ();
   fifo_sync_asym_packer_if #(.WR_WIDTH(W), .RATIO(R), .DEPTH(D)) b2 ();
   fifo_sync_asym_packer #(.WR_WIDTH(W), .RATIO(R), .PACK_ORDER("MSB_FIRST"), .DEPTH(D),
      .OUTPUT_REG(0), .PF_ASSERT(6), .PF_NEGATE(4), .PE_ASSERT(1), .PE_NEGATE(3),
      .RST_BUSY_CYCLES(2)) dut (.clk_i(clk), .a_rst_n_i(a_rst_n), .bus(b1));
   fifo_sync_asym_packer #(.WR_WIDTH(W), .RATIO(R), .PACK_ORDER("LSB_FIRST"), .DEPTH(D),
      .OUTPUT_REG(1), .PF_ASSERT(6), .PF_NEGATE(4), .PE_ASSERT(1), .PE_NEGATE(3),
      .RST_BUSY_CYCLES(2)) dut2 (.clk_i(clk), .a_rst_n_i(a_rst_n), .bus(b2));

   function automatic logic [3:0] e_cnt();
      return 4'(m_q.size());
   endfunction
   function automatic logic e_full();
      return m_q.size() == D && m_part.size() == R - 1;
   endfunction

   task automatic model_reset();
      m_q.delete(); m_part.delete();
      m_rdata = '0; m_valid = 0; m_of = 0; m_uf = 0; m_pf = 0; m_pe = 1; m_bl = 2;
   endtask

   // One clock of stimulus on the main DUT; the model applies the rules to the pre-edge state.
   task automatic step(input bit wr, input logic [15:0] d, input bit rd, input bit fl);
      logic [31:0] w;
      int c;
      bit busy;
      b1.wr_en_i = wr; b1.wdata = d; b1.rd_en_i = rd; b1.flush_i = fl;
      @(posedge clk);
      busy = m_bl > 0;
      if (busy) m_bl--;
      c = m_q.size();
      m_of = 0; m_uf = 0; m_valid = 0;
      if (!busy && fl) begin
         m_q.delete(); m_part.delete();
      end else if (!busy) begin
         if (rd && c > 0) begin m_rdata = m_q.pop_front(); m_valid = 1; end
         else if (rd) m_uf = 1;
         if (wr && c == D && m_part.size() == R - 1) m_of = 1;
         else if (wr) begin
            m_part.push_back(d);
            if (m_part.size() == R) begin
               w = '0;
               for (int k = 0; k < R; k++) w[(R-1-k)*W +: W] = m_part[k];
               m_q.push_back(w);
               m_part.delete();
            end
         end
      end
      m_pf = (!busy && fl) ? 1'b0 : c >= 6 ? 1'b1 : c < 4 ? 1'b0 : m_pf;
      m_pe = (!busy && fl) ? 1'b1 : c <= 1 ? 1'b1 : c > 3 ? 1'b0 : m_pe;
      #1;
   endtask

   task automatic test_reset();
      {b1.flush_i, b1.wr_en_i, b1.rd_en_i} = '0; b1.wdata = '0;
      {b2.flush_i, b2.wr_en_i, b2.rd_en_i} = '0; b2.wdata = '0;
      a_rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_chk++; if (b1.rdata !== 32'h0) $display("FAIL reset rdata: got %h want 0", b1.rdata); else n_pass++;
      n_chk++; if (b1.rd_valid_o !== 1'b0) $display("FAIL reset rd_valid: got %b want 0", b1.rd_valid_o); else n_pass++;
      n_chk++; if (b1.full_o !== 1'b0) $display("FAIL reset full: got %b want 0", b1.full_o); else n_pass++;
      n_chk++; if (b1.empty_o !== 1'b1) $display("FAIL reset empty: got %b want 1", b1.empty_o); else n_pass++;
      n_chk++; if (b1.prog_full_o !== 1'b0) $display("FAIL reset prog_full: got %b want 0", b1.prog_full_o); else n_pass++;
      n_chk++; if (b1.prog_empty_o !== 1'b1) $display("FAIL reset prog_empty: got %b want 1", b1.prog_empty_o); else n_pass++;
      n_chk++; if (b1.count_o !== 4'd0) $display("FAIL reset count: got %0d want 0", b1.count_o); else n_pass++;
      n_chk++; if (b1.overflow_o !== 1'b0) $display("FAIL reset overflow: got %b want 0", b1.overflow_o); else n_pass++;
      n_chk++; if (b1.underflow_o !== 1'b0) $display("FAIL reset underflow: got %b want 0", b1.underflow_o); else n_pass++;
      n_chk++; if (b1.rst_busy_o !== 1'b1) $display("FAIL reset rst_busy: got %b want 1", b1.rst_busy_o); else n_pass++;
      a_rst_n = 1;
      step(1, 16'h1234, 0, 0);
      n_chk++; if (b1.rst_busy_o !== 1'b1) $display("FAIL busy cycle1: got %b want 1", b1.rst_busy_o); else n_pass++;
      step(1, 16'h5678, 1, 0);
      n_chk++; if (b1.rst_busy_o !== 1'b0) $display("FAIL busy cycle2: got %b want 0", b1.rst_busy_o); else n_pass++;
      n_chk++; if (b1.count_o !== 4'd0 || b1.empty_o !== 1'b1) $display("FAIL busy writes ignored: got count %0d empty %b want 0 1", b1.count_o, b1.empty_o); else n_pass++;
      n_chk++; if (b1.underflow_o !== 1'b0) $display("FAIL busy read no pulse: got %b want 0", b1.underflow_o); else n_pass++;
   endtask

   task automatic test_pack_order();
      step(1, 16'h0001, 0, 0);
      n_chk++; if (b1.empty_o !== 1'b1 || b1.count_o !== 4'd0) $display("FAIL partial empty: got empty %b count %0d want 1 0", b1.empty_o, b1.count_o); else n_pass++;
      step(1, 16'h0002, 0, 0);
      n_chk++; if (b1.empty_o !== 1'b0 || b1.count_o !== 4'd1) $display("FAIL packed empty: got empty %b count %0d want 0 1", b1.empty_o, b1.count_o); else n_pass++;
      step(0, 0, 1, 0);
      n_chk++; if (b1.rd_valid_o !== 1'b1 || b1.rdata !== 32'h00010002) $display("FAIL msb read: got v %b d %h want 1 00010002", b1.rd_valid_o, b1.rdata); else n_pass++;
      step(0, 0, 0, 0);
      n_chk++; if (b1.rd_valid_o !== 1'b0 || b1.rdata !== 32'h00010002) $display("FAIL rdata hold: got v %b d %h want 0 00010002", b1.rd_valid_o, b1.rdata); else n_pass++;
   endtask

   task automatic test_lsb_oreg();
      b2.wr_en_i = 1; b2.wdata = 16'h0001;
      @(posedge clk); #1;
      b2.wdata = 16'h0002;
      @(posedge clk); #1;
      b2.wr_en_i = 0;
      n_chk++; if (b2.count_o !== 4'd1) $display("FAIL lsb count: got %0d want 1", b2.count_o); else n_pass++;
      b2.rd_en_i = 1;
      @(posedge clk); #1;
      b2.rd_en_i = 0;
      n_chk++; if (b2.rd_valid_o !== 1'b0) $display("FAIL oreg early valid: got %b want 0", b2.rd_valid_o); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (b2.rd_valid_o !== 1'b1 || b2.rdata !== 32'h00020001) $display("FAIL lsb oreg read: got v %b d %h want 1 00020001", b2.rd_valid_o, b2.rdata); else n_pass++;
      b2.wr_en_i = 1; b2.wdata = 16'h0003;
      @(posedge clk); #1;
      b2.wdata = 16'h0004;
      @(posedge clk); #1;
      b2.wr_en_i = 0; b2.rd_en_i = 1;
      @(posedge clk); #1;
      b2.rd_en_i = 0; b2.flush_i = 1;
      @(posedge clk); #1;
      b2.flush_i = 0;
      n_chk++; if (b2.rd_valid_o !== 1'b0 || b2.rdata !== 32'h00020001) $display("FAIL flush cancels valid: got v %b d %h want 0 00020001", b2.rd_valid_o, b2.rdata); else n_pass++;
      n_chk++; if (b2.count_o !== 4'd0 || b2.empty_o !== 1'b1) $display("FAIL oreg flush count: got %0d empty %b want 0 1", b2.count_o, b2.empty_o); else n_pass++;
   endtask

   task automatic test_full_overflow();
      for (int i = 1; i <= 17; i++) step(1, 16'(i), 0, 0);
      n_chk++; if (b1.count_o !== 4'd8 || b1.full_o !== 1'b1) $display("FAIL full: got count %0d full %b want 8 1", b1.count_o, b1.full_o); else n_pass++;
      step(1, 16'd18, 0, 0);
      n_chk++; if (b1.overflow_o !== 1'b1 || b1.overflow_o !== m_of) $display("FAIL overflow pulse: got %b want 1", b1.overflow_o); else n_pass++;
      step(0, 0, 0, 0);
      n_chk++; if (b1.overflow_o !== 1'b0) $display("FAIL overflow single: got %b want 0", b1.overflow_o); else n_pass++;
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 1, 0);
         n_chk++; if (b1.rd_valid_o !== 1'b1 || b1.rdata !== {16'(2*k+1), 16'(2*k+2)}) $display("FAIL drain %0d: got v %b d %h want 1 %h", k, b1.rd_valid_o, b1.rdata, {16'(2*k+1), 16'(2*k+2)}); else n_pass++;
      end
      step(1, 16'h0012, 0, 0);
      step(0, 0, 1, 0);
      n_chk++; if (b1.rdata !== 32'h00110012) $display("FAIL packer kept word17: got %h want 00110012", b1.rdata); else n_pass++;
   endtask

   task automatic test_prog_flags();
      for (int i = 0; i < 12; i++) begin
         step(1, 16'(i), 0, 0);
         n_chk++; if (b1.count_o !== e_cnt() || b1.prog_full_o !== m_pf || b1.prog_empty_o !== m_pe) $display("FAIL flags fill %0d: got c %0d pf %b pe %b want %0d %b %b", i, b1.count_o, b1.prog_full_o, b1.prog_empty_o, e_cnt(), m_pf, m_pe); else n_pass++;
         if (i == 7) begin n_chk++; if (b1.prog_empty_o !== 1'b1) $display("FAIL pe at count4: got %b want 1", b1.prog_empty_o); else n_pass++; end
         if (i == 8) begin n_chk++; if (b1.prog_empty_o !== 1'b0) $display("FAIL pe after count4: got %b want 0", b1.prog_empty_o); else n_pass++; end
      end
      n_chk++; if (b1.count_o !== 4'd6 || b1.prog_full_o !== 1'b0) $display("FAIL pf lag: got c %0d pf %b want 6 0", b1.count_o, b1.prog_full_o); else n_pass++;
      step(0, 0, 0, 0);
      n_chk++; if (b1.prog_full_o !== 1'b1) $display("FAIL pf rise: got %b want 1", b1.prog_full_o); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0);
         n_chk++; if (b1.prog_full_o !== 1'b1) $display("FAIL pf hold %0d: got %b want 1", i, b1.prog_full_o); else n_pass++;
      end
      step(0, 0, 0, 0);
      n_chk++; if (b1.prog_full_o !== 1'b0 || b1.count_o !== 4'd3) $display("FAIL pf fall: got pf %b c %0d want 0 3", b1.prog_full_o, b1.count_o); else n_pass++;
      step(0, 0, 0, 1);
      n_chk++; if (b1.count_o !== 4'd0 || b1.prog_empty_o !== 1'b1 || b1.prog_full_o !== 1'b0 || b1.empty_o !== 1'b1) $display("FAIL flush flags: got c %0d pe %b pf %b e %b want 0 1 0 1", b1.count_o, b1.prog_empty_o, b1.prog_full_o, b1.empty_o); else n_pass++;
   endtask

   task automatic test_underflow();
      step(0, 0, 1, 0);
      n_chk++; if (b1.underflow_o !== 1'b1 || b1.rd_valid_o !== 1'b0) $display("FAIL underflow: got uf %b v %b want 1 0", b1.underflow_o, b1.rd_valid_o); else n_pass++;
      step(0, 0, 0, 0);
      n_chk++; if (b1.underflow_o !== 1'b0) $display("FAIL underflow single: got %b want 0", b1.underflow_o); else n_pass++;
      step(1, 16'h0005, 0, 0);
      step(1, 16'h0006, 1, 0);
      n_chk++; if (b1.underflow_o !== 1'b1 || b1.rd_valid_o !== 1'b0 || b1.count_o !== 4'd1) $display("FAIL read with completing write: got uf %b v %b c %0d want 1 0 1", b1.underflow_o, b1.rd_valid_o, b1.count_o); else n_pass++;
      step(0, 0, 0, 1);
   endtask

   task automatic test_flush();
      step(1, 16'h0007, 0, 0);
      step(1, 16'h0008, 0, 1);
      n_chk++; if (b1.count_o !== 4'd0 || b1.empty_o !== 1'b1) $display("FAIL flush over write: got c %0d e %b want 0 1", b1.count_o, b1.empty_o); else n_pass++;
      step(1, 16'hAAAA, 0, 0);
      step(1, 16'hBBBB, 0, 0);
      step(0, 0, 1, 0);
      n_chk++; if (b1.rdata !== 32'hAAAABBBB || b1.rd_valid_o !== 1'b1) $display("FAIL flush repack: got d %h v %b want AAAABBBB 1", b1.rdata, b1.rd_valid_o); else n_pass++;
   endtask

   task automatic test_random();
      int pw, pr;
      bit wr, rd, fl;
      for (int i = 0; i < 400; i++) begin
         pw = (i / 100 == 0) ? 85 : (i / 100 == 1) ? 25 : (i / 100 == 2) ? 90 : 50;
         pr = 100 - pw + 5;
         wr = $urandom_range(0, 99) < pw;
         rd = $urandom_range(0, 99) < pr;
         fl = $urandom_range(0, 79) == 0;
         step(wr, 16'($urandom), rd, fl);
         n_chk++;
         if (b1.rdata !== m_rdata || b1.rd_valid_o !== m_valid || b1.full_o !== e_full() ||
             b1.empty_o !== (m_q.size() == 0) || b1.count_o !== e_cnt() || b1.prog_full_o !== m_pf ||
             b1.prog_empty_o !== m_pe || b1.overflow_o !== m_of || b1.underflow_o !== m_uf || b1.rst_busy_o !== 1'b0)
            $display("FAIL random cycle %0d: got d %h v %b f %b e %b c %0d pf %b pe %b of %b uf %b want d %h v %b f %b c %0d pf %b pe %b of %b uf %b",
               i, b1.rdata, b1.rd_valid_o, b1.full_o, b1.empty_o, b1.count_o, b1.prog_full_o, b1.prog_empty_o, b1.overflow_o, b1.underflow_o,
               m_rdata, m_valid, e_full(), e_cnt(), m_pf, m_pe, m_of, m_uf);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 16'(i + 16'h40), 0, 0);
      n_chk++; if (b1.count_o !== 4'd5) $display("FAIL pre-reset count: got %0d want 5", b1.count_o); else n_pass++;
      step(0, 0, 1, 0);
      step(1, 16'h0001, 0, 0);
      a_rst_n = 0;
      #1;
      n_chk++; if (b1.count_o !== 4'd0 || b1.empty_o !== 1'b1 || b1.rdata !== 32'h0 || b1.rst_busy_o !== 1'b1) $display("FAIL async reset: got c %0d e %b d %h busy %b want 0 1 0 1", b1.count_o, b1.empty_o, b1.rdata, b1.rst_busy_o); else n_pass++;
      n_chk++; if (b1.prog_full_o !== 1'b0 || b1.prog_empty_o !== 1'b1 || b1.rd_valid_o !== 1'b0 || b1.full_o !== 1'b0) $display("FAIL async reset flags: got pf %b pe %b v %b f %b want 0 1 0 0", b1.prog_full_o, b1.prog_empty_o, b1.rd_valid_o, b1.full_o); else n_pass++;
      @(posedge clk); #1;
      a_rst_n = 1;
      model_reset();
      step(1, 16'h0F0F, 0, 0);
      n_chk++; if (b1.rst_busy_o !== 1'b1 || b1.count_o !== 4'd0) $display("FAIL busy after mid reset: got busy %b c %0d want 1 0", b1.rst_busy_o, b1.count_o); else n_pass++;
      step(1, 16'hF0F0, 0, 0);
      n_chk++; if (b1.rst_busy_o !== 1'b0 || b1.count_o !== 4'd0) $display("FAIL busy end: got busy %b c %0d want 0 0", b1.rst_busy_o, b1.count_o); else n_pass++;
      step(1, 16'hC0DE, 0, 0);
      step(1, 16'hBEEF, 0, 0);
      step(0, 0, 1, 0);
      n_chk++; if (b1.rdata !== 32'hC0DEBEEF) $display("FAIL post reset data: got %h want C0DEBEEF", b1.rdata); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_pack_order();
      test_lsb_oreg();
      test_full_overflow();
      test_prog_flags();
      test_underflow();
      test_flush();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
